// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC scan sequencer: channel addresses,
// the scan-index to address lookup and the FSM state encoding.
package adc_seq_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned IDX_W  = 2;

  localparam logic [ADDR_W-1:0] CH7_ADDR  = 7'h17;
  localparam logic [ADDR_W-1:0] CH14_ADDR = 7'h1E;
  localparam logic [ADDR_W-1:0] CH15_ADDR = 7'h1F;

  // Index of the final conversion in a scan; its drdy triggers publication.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

  // Scan index to ADC channel address.
  function automatic logic [ADDR_W-1:0] ch_addr(input logic [IDX_W-1:0] idx);
    logic [ADDR_W-1:0] addr;
    case (idx)
      2'd0:    addr = CH7_ADDR;
      2'd1:    addr = CH14_ADDR;
      2'd2:    addr = CH15_ADDR;
      default: addr = CH7_ADDR;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/adc_seq_timeout.sv
// Loadable down-counter with an expiry flag.
// Ports:
//   clk_100m, rst_ni : clock, async active-low reset
//   load, load_val   : load the counter (takes priority over counting)
//   count_en         : decrement by one per cycle, stopping at zero
//   expired_c        : counter is zero (combinational from the count register)
module adc_seq_timeout #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk_100m,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count_en,
  output logic             expired_c
);

  logic [CNT_W-1:0] cnt_q;

  // Count register; holds at zero once expired.
  always_ff @(posedge clk_100m or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (count_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// Sequences the ch7/ch14/ch15 ADC conversions for the 3LFCC control loop
// and publishes a coherent sample set with a one-cycle valid strobe.
// Ports:
//   clk_100m, rst_ni          : clock, async active-low reset
//   enable_i, trig_i          : scan request gating and request strobe
//   clear_i                   : clears timeout flag and overrun counter
//   adc_start_o, adc_addr_o   : conversion start strobe and channel address
//   adc_drdy_i, adc_data_i    : conversion result strobe and data
//   v_in_o/v_out_o/v_low_o    : published ch7/ch14/ch15 results
//   v_fc_o                    : ch7 - ch15, clamped at zero
//   sample_valid_o            : one-cycle publication strobe
//   busy_o                    : scan in progress
//   timeout_o, overrun_cnt_o  : sticky timeout, saturating dropped-trigger count
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned OVR_W          = 8
) (
  input  logic              clk_100m,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              trig_i,
  input  logic              clear_i,
  output logic              adc_start_o,
  output logic [ADDR_W-1:0] adc_addr_o,
  input  logic              adc_drdy_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic [DATA_W-1:0] v_in_o,
  output logic [DATA_W-1:0] v_out_o,
  output logic [DATA_W-1:0] v_low_o,
  output logic [DATA_W-1:0] v_fc_o,
  output logic              sample_valid_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [OVR_W-1:0]  overrun_cnt_o
);

  localparam int unsigned      TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [OVR_W-1:0] OVR_MAX  = '1;

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] ch7_q, ch7_d;
  logic [DATA_W-1:0] ch14_q, ch14_d;
  logic [DATA_W-1:0] v_in_q, v_in_d;
  logic [DATA_W-1:0] v_out_q, v_out_d;
  logic [DATA_W-1:0] v_low_q, v_low_d;
  logic [DATA_W-1:0] v_fc_q, v_fc_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic              timer_expired_c;

  // Per-conversion watchdog: loaded in START so WAIT begins at the full budget.
  adc_seq_timeout #(
    .CNT_W (TMR_W)
  ) u_timeout (
    .clk_100m  (clk_100m),
    .rst_ni    (rst_ni),
    .load      (state_q == ST_START),
    .load_val  (TMR_LOAD),
    .count_en  (state_q == ST_WAIT),
    .expired_c (timer_expired_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ch7_d     = ch7_q;
    ch14_d    = ch14_q;
    v_in_d    = v_in_q;
    v_out_d   = v_out_q;
    v_low_d   = v_low_q;
    v_fc_d    = v_fc_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q & ~clear_i;
    ovr_d     = clear_i ? '0 : ovr_q;

    // A trigger while busy is dropped; the increment overrides a coincident clear.
    if (trig_i && (state_q != ST_IDLE)) begin
      ovr_d = (ovr_q == OVR_MAX) ? ovr_q : ovr_q + OVR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (trig_i && enable_i) begin
          state_d = ST_START;
          idx_d   = '0;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (adc_drdy_i) begin
          if (idx_q == LAST_IDX) begin
            // ch15 is taken straight from the bus so all four outputs load together.
            v_in_d  = ch7_q;
            v_out_d = ch14_q;
            v_low_d = adc_data_i;
            v_fc_d  = (ch7_q >= adc_data_i) ? (ch7_q - adc_data_i) : '0;
            valid_d = 1'b1;
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            if (idx_q == '0) begin
              ch7_d = adc_data_i;
            end else begin
              ch14_d = adc_data_i;
            end
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_START;
          end
        end else if (timer_expired_c) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          idx_d     = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    start_d = (state_d == ST_START);
    busy_d  = (state_d != ST_IDLE);
    addr_d  = (state_d == ST_IDLE) ? CH7_ADDR : ch_addr(idx_d);
  end

  // State and output registers.
  always_ff @(posedge clk_100m or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ch7_q     <= '0;
      ch14_q    <= '0;
      v_in_q    <= '0;
      v_out_q   <= '0;
      v_low_q   <= '0;
      v_fc_q    <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      addr_q    <= CH7_ADDR;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ch7_q     <= ch7_d;
      ch14_q    <= ch14_d;
      v_in_q    <= v_in_d;
      v_out_q   <= v_out_d;
      v_low_q   <= v_low_d;
      v_fc_q    <= v_fc_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ovr_q     <= ovr_d;
    end
  end

  assign adc_start_o    = start_q;
  assign adc_addr_o     = addr_q;
  assign v_in_o         = v_in_q;
  assign v_out_o        = v_out_q;
  assign v_low_o        = v_low_q;
  assign v_fc_o         = v_fc_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign timeout_o      = timeout_q;
  assign overrun_cnt_o  = ovr_q;

endmodule
